// File: rtl/instruction_fetch_stage.sv
// ----------------------------------------------------------------------------
// instruction_fetch_stage
//
// Fetch stage plus IF/ID pipeline register for the vector processor. Holds
// the PC and drives it straight out as the instruction-memory address. The
// returned word is latched with its PC into the IF/ID register that feeds the
// decoder. Hazard stalls, branch redirect/flush and a drain-then-halt
// sequence on the end-of-program word are handled by a three-state FSM.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high
//   imem_addr     out  instruction-memory address (the PC register)
//   imem_data     in   instruction word, combinational read of imem_addr
//   stall         in   hazard unit: hold PC and IF/ID
//   branch_taken  in   branch unit: redirect to branch_target and flush IF/ID
//   branch_target in   redirect address
//   ifid_instr    out  IF/ID instruction word
//   ifid_pc       out  PC of ifid_instr
//   ifid_valid    out  1 = ifid_instr is a real fetched instruction
//   halted        out  processor has halted
//   fetch_count   out  saturating count of instructions accepted into IF/ID
// ----------------------------------------------------------------------------
module instruction_fetch_stage #(
    parameter int          PC_W         = 32,
    parameter int          PC_STEP      = 4,
    parameter logic [31:0] NOP_WORD     = 32'hF000_0000,
    parameter logic [31:0] HALT_WORD    = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [31:0]     ifid_instr,
    output logic [PC_W-1:0] ifid_pc,
    output logic            ifid_valid,
    output logic            halted,
    output logic [31:0]     fetch_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [3:0]      DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_INC     = PC_W'(PC_STEP);

    // Counter saturates rather than wrapping so a long run never reads as short.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_p0, pc_d;
    logic [31:0]     instr_p1, instr_d;
    logic [PC_W-1:0] ifid_pc_p1, ifid_pc_d;
    logic            vld_p1, vld_d;
    logic [31:0]     count_q, count_d;
    logic [3:0]      drain_q, drain_d;
    logic            halted_q, halted_d;

    // Next-state / next-register logic. imem_data is only examined on a
    // normal RUN advance, so X on the bus while stalled, draining or halted
    // never reaches any register.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_p0;
        instr_d   = instr_p1;
        ifid_pc_d = ifid_pc_p1;
        vld_d     = vld_p1;
        count_d   = count_q;
        drain_d   = drain_q;
        halted_d  = halted_q;

        unique case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    instr_d = NOP_WORD;
                    vld_d   = 1'b0;
                    drain_d = 4'd0;
                end else if (!stall) begin
                    instr_d   = imem_data;
                    ifid_pc_d = pc_p0;
                    vld_d     = 1'b1;
                    count_d   = sat_inc(count_q);
                    if (imem_data == HALT_WORD) begin
                        // Halt word is issued normally; PC freezes on it.
                        state_d = ST_DRAIN;
                        drain_d = 4'd0;
                    end else begin
                        pc_d = pc_p0 + PC_INC;
                    end
                end
            end

            ST_DRAIN: begin
                if (branch_taken) begin
                    // Halt word was fetched on a mispredicted path.
                    pc_d    = branch_target;
                    instr_d = NOP_WORD;
                    vld_d   = 1'b0;
                    drain_d = 4'd0;
                    state_d = ST_RUN;
                end else if (!stall) begin
                    instr_d = NOP_WORD;
                    vld_d   = 1'b0;
                    drain_d = drain_q + 4'd1;
                    if (drain_q == DRAIN_LAST) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                end
            end

            ST_HALT: begin
                instr_d  = NOP_WORD;
                vld_d    = 1'b0;
                halted_d = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ---- stage boundary: PC (p0) and IF/ID register (p1) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_p0      <= '0;
            instr_p1   <= NOP_WORD;
            ifid_pc_p1 <= '0;
            vld_p1     <= 1'b0;
            count_q    <= 32'd0;
            drain_q    <= 4'd0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_p0      <= pc_d;
            instr_p1   <= instr_d;
            ifid_pc_p1 <= ifid_pc_d;
            vld_p1     <= vld_d;
            count_q    <= count_d;
            drain_q    <= drain_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_addr   = pc_p0;
    assign ifid_instr  = instr_p1;
    assign ifid_pc     = ifid_pc_p1;
    assign ifid_valid  = vld_p1;
    assign halted      = halted_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:255];
    logic        xmode = 1'b0;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    always #5 clk = ~clk;

    // Instruction memory model: low 1 KiB from mem[], higher addresses a
    // fixed pattern; xmode drives the bus to X to model an idle memory.
    always_comb begin
        if (xmode)
            imem_data = 'x;
        else if (imem_addr < 32'd1024)
            imem_data = mem[imem_addr[9:2]];
        else
            imem_data = 32'hA000_0000 ^ imem_addr;
    end

    instruction_fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_valid   (ifid_valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall = 1'b0;
        branch_taken = 1'b0;
        xmode = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++; if (imem_addr !== 32'd0) begin err_cnt++; $display("FAIL reset_addr got %h want %h", imem_addr, 32'd0); end
        vec_cnt++; if (ifid_instr !== 32'hF000_0000) begin err_cnt++; $display("FAIL reset_instr got %h want %h", ifid_instr, 32'hF000_0000); end
        vec_cnt++; if (ifid_pc !== 32'd0) begin err_cnt++; $display("FAIL reset_pc got %h want %h", ifid_pc, 32'd0); end
        vec_cnt++; if (ifid_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got %b want 0", ifid_valid); end
        vec_cnt++; if (halted !== 1'b0) begin err_cnt++; $display("FAIL reset_halted got %b want 0", halted); end
        vec_cnt++; if (fetch_count !== 32'd0) begin err_cnt++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            vec_cnt++; if (ifid_instr !== 32'h1000_0000 + i) begin err_cnt++; $display("FAIL seq_instr[%0d] got %h want %h", i, ifid_instr, 32'h1000_0000 + i); end
            vec_cnt++; if (ifid_pc !== 32'(4 * i)) begin err_cnt++; $display("FAIL seq_pc[%0d] got %h want %h", i, ifid_pc, 4 * i); end
            vec_cnt++; if (ifid_valid !== 1'b1) begin err_cnt++; $display("FAIL seq_valid[%0d] got %b want 1", i, ifid_valid); end
            vec_cnt++; if (imem_addr !== 32'(4 * (i + 1))) begin err_cnt++; $display("FAIL seq_addr[%0d] got %h want %h", i, imem_addr, 4 * (i + 1)); end
        end
        vec_cnt++; if (fetch_count !== 32'd4) begin err_cnt++; $display("FAIL seq_count got %0d want 4", fetch_count); end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        xmode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec_cnt++; if (imem_addr !== 32'h8) begin err_cnt++; $display("FAIL stall_addr[%0d] got %h want %h", i, imem_addr, 32'h8); end
            vec_cnt++; if (ifid_instr !== 32'h1000_0001) begin err_cnt++; $display("FAIL stall_instr[%0d] got %h want %h", i, ifid_instr, 32'h1000_0001); end
            vec_cnt++; if (ifid_pc !== 32'h4) begin err_cnt++; $display("FAIL stall_pc[%0d] got %h want %h", i, ifid_pc, 32'h4); end
            vec_cnt++; if (fetch_count !== 32'd2) begin err_cnt++; $display("FAIL stall_count[%0d] got %0d want 2", i, fetch_count); end
        end
        stall = 1'b0;
        xmode = 1'b0;
        tick();
        vec_cnt++; if (ifid_instr !== 32'h1000_0002) begin err_cnt++; $display("FAIL unstall_instr got %h want %h", ifid_instr, 32'h1000_0002); end
        vec_cnt++; if (ifid_pc !== 32'h8) begin err_cnt++; $display("FAIL unstall_pc got %h want %h", ifid_pc, 32'h8); end
        vec_cnt++; if (fetch_count !== 32'd3) begin err_cnt++; $display("FAIL unstall_count got %0d want 3", fetch_count); end
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        branch_taken = 1'b1;
        branch_target = 32'h40;
        stall = 1'b1;
        tick();
        branch_taken = 1'b0;
        stall = 1'b0;
        vec_cnt++; if (imem_addr !== 32'h40) begin err_cnt++; $display("FAIL br_addr got %h want %h", imem_addr, 32'h40); end
        vec_cnt++; if (ifid_instr !== 32'hF000_0000) begin err_cnt++; $display("FAIL br_instr got %h want %h", ifid_instr, 32'hF000_0000); end
        vec_cnt++; if (ifid_valid !== 1'b0) begin err_cnt++; $display("FAIL br_valid got %b want 0", ifid_valid); end
        vec_cnt++; if (ifid_pc !== 32'hC) begin err_cnt++; $display("FAIL br_pc_hold got %h want %h", ifid_pc, 32'hC); end
        vec_cnt++; if (fetch_count !== 32'd4) begin err_cnt++; $display("FAIL br_count got %0d want 4", fetch_count); end
        tick();
        vec_cnt++; if (ifid_pc !== 32'h40) begin err_cnt++; $display("FAIL br_tgt_pc got %h want %h", ifid_pc, 32'h40); end
        vec_cnt++; if (ifid_instr !== 32'h1000_0010) begin err_cnt++; $display("FAIL br_tgt_instr got %h want %h", ifid_instr, 32'h1000_0010); end
        vec_cnt++; if (ifid_valid !== 1'b1) begin err_cnt++; $display("FAIL br_tgt_valid got %b want 1", ifid_valid); end
        vec_cnt++; if (fetch_count !== 32'd5) begin err_cnt++; $display("FAIL br_tgt_count got %0d want 5", fetch_count); end
    endtask

    task automatic test_halt();
        mem[8] = 32'h0000_0000;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        vec_cnt++; if (imem_addr !== 32'h20) begin err_cnt++; $display("FAIL halt_pre_addr got %h want %h", imem_addr, 32'h20); end
        tick();
        vec_cnt++; if (ifid_instr !== 32'h0) begin err_cnt++; $display("FAIL halt_word got %h want %h", ifid_instr, 32'h0); end
        vec_cnt++; if (ifid_valid !== 1'b1) begin err_cnt++; $display("FAIL halt_word_valid got %b want 1", ifid_valid); end
        vec_cnt++; if (ifid_pc !== 32'h20) begin err_cnt++; $display("FAIL halt_word_pc got %h want %h", ifid_pc, 32'h20); end
        vec_cnt++; if (fetch_count !== 32'd9) begin err_cnt++; $display("FAIL halt_word_count got %0d want 9", fetch_count); end
        xmode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec_cnt++; if (halted !== 1'b0) begin err_cnt++; $display("FAIL drain_halted[%0d] got %b want 0", i, halted); end
            vec_cnt++; if (imem_addr !== 32'h20) begin err_cnt++; $display("FAIL drain_addr[%0d] got %h want %h", i, imem_addr, 32'h20); end
            vec_cnt++; if (ifid_instr !== 32'hF000_0000 || ifid_valid !== 1'b0) begin err_cnt++; $display("FAIL drain_bubble[%0d] got %h/%b want f0000000/0", i, ifid_instr, ifid_valid); end
        end
        tick();
        vec_cnt++; if (halted !== 1'b1) begin err_cnt++; $display("FAIL halt_entry got %b want 1", halted); end
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h80;
        for (int i = 0; i < 2; i++) begin
            tick();
            vec_cnt++; if (halted !== 1'b1) begin err_cnt++; $display("FAIL halt_hold[%0d] got %b want 1", i, halted); end
            vec_cnt++; if (imem_addr !== 32'h20) begin err_cnt++; $display("FAIL halt_addr[%0d] got %h want %h", i, imem_addr, 32'h20); end
            vec_cnt++; if (ifid_instr !== 32'hF000_0000 || ifid_valid !== 1'b0) begin err_cnt++; $display("FAIL halt_bubble[%0d] got %h/%b want f0000000/0", i, ifid_instr, ifid_valid); end
            vec_cnt++; if (fetch_count !== 32'd9) begin err_cnt++; $display("FAIL halt_count[%0d] got %0d want 9", i, fetch_count); end
        end
        stall = 1'b0;
        branch_taken = 1'b0;
        xmode = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vec_cnt++; if (halted !== 1'b0) begin err_cnt++; $display("FAIL halt_reset_halted got %b want 0", halted); end
        vec_cnt++; if (imem_addr !== 32'd0) begin err_cnt++; $display("FAIL halt_reset_addr got %h want 0", imem_addr); end
        vec_cnt++; if (fetch_count !== 32'd0) begin err_cnt++; $display("FAIL halt_reset_count got %0d want 0", fetch_count); end
    endtask

    task automatic test_drain_branch();
        do_reset();
        for (int i = 0; i < 9; i++) tick();
        tick();
        tick();
        branch_taken = 1'b1;
        branch_target = 32'h80;
        tick();
        branch_taken = 1'b0;
        vec_cnt++; if (halted !== 1'b0) begin err_cnt++; $display("FAIL dbr_halted got %b want 0", halted); end
        vec_cnt++; if (imem_addr !== 32'h80) begin err_cnt++; $display("FAIL dbr_addr got %h want %h", imem_addr, 32'h80); end
        vec_cnt++; if (ifid_valid !== 1'b0) begin err_cnt++; $display("FAIL dbr_valid got %b want 0", ifid_valid); end
        tick();
        vec_cnt++; if (ifid_pc !== 32'h80) begin err_cnt++; $display("FAIL dbr_tgt_pc got %h want %h", ifid_pc, 32'h80); end
        vec_cnt++; if (ifid_instr !== 32'h1000_0020) begin err_cnt++; $display("FAIL dbr_tgt_instr got %h want %h", ifid_instr, 32'h1000_0020); end
        vec_cnt++; if (fetch_count !== 32'd10) begin err_cnt++; $display("FAIL dbr_count got %0d want 10", fetch_count); end
        for (int i = 0; i < 5; i++) tick();
        vec_cnt++; if (halted !== 1'b0 || imem_addr !== 32'h98) begin err_cnt++; $display("FAIL dbr_run got %b/%h want 0/00000098", halted, imem_addr); end
        mem[8] = 32'h1000_0008;
    endtask

    task automatic test_wrap();
        do_reset();
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        vec_cnt++; if (imem_addr !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL wrap_pre got %h want fffffffc", imem_addr); end
        tick();
        vec_cnt++; if (imem_addr !== 32'd0) begin err_cnt++; $display("FAIL wrap_addr got %h want 0", imem_addr); end
        vec_cnt++; if (ifid_pc !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL wrap_pc got %h want fffffffc", ifid_pc); end
        vec_cnt++; if (ifid_instr !== 32'h5FFF_FFFC) begin err_cnt++; $display("FAIL wrap_instr got %h want 5ffffffc", ifid_instr); end
        vec_cnt++; if (ifid_valid !== 1'b1 || halted !== 1'b0) begin err_cnt++; $display("FAIL wrap_flags got %b/%b want 1/0", ifid_valid, halted); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_halt();
        test_drain_branch();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
